// File: rtl/eth_mdio_pkg.sv
// Shared types and frame constants for the clause-22 MDIO management controller.
package eth_mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_DONE
  } mdio_state_t;

  localparam logic [1:0] MDIO_ST        = 2'b01;
  localparam logic [1:0] MDIO_OP_WR     = 2'b01;
  localparam logic [1:0] MDIO_OP_RD     = 2'b10;
  localparam int         MDIO_HDR_BITS  = 14;
  localparam int         MDIO_DATA_BITS = 16;

  // Everything after the preamble, MSB first: ST, OP, PHYAD, REGAD, TA, DATA.
  // Read frames carry zeros in the TA/DATA slots since the PHY owns the line there.
  function automatic logic [31:0] mdio_frame(input logic        wr,
                                             input logic [4:0]  phy,
                                             input logic [4:0]  reg_addr,
                                             input logic [15:0] wdata);
    return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phy, reg_addr,
            (wr ? 2'b10 : 2'b00), (wr ? wdata : 16'h0000)};
  endfunction

endpackage

// File: rtl/eth_mdio_clkgen.sv
// MDC divider: low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit.
// Held in the low phase with the counter cleared while disabled, so every
// frame starts on a fresh low phase.
module eth_mdio_clkgen #(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic o_emdc,
  output logic fall_stb,
  output logic sample_stb
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  // Phase counter and MDC level; MDC toggles at the end of each half-period.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      o_emdc  <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      o_emdc  <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= '0;
      o_emdc  <= ~o_emdc;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Last cycle of the high phase: mdio_i is sampled now, and the next bit is
  // launched on the edge that ends this cycle (the falling MDC edge).
  assign sample_stb = en & o_emdc & phase_end;
  assign fall_stb   = en & o_emdc & phase_end;

endmodule

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO master: accepts one register read/write request, serialises
// the frame on MDC/MDIO and returns read data plus a turnaround error flag.
module eth_mdio_master
  import eth_mdio_pkg::*;
#(
  parameter int CLK_DIV       = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_emdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LOAD  = (PREAMBLE_BITS > 0) ? 6'(PREAMBLE_BITS - 1) : 6'd0;
  localparam logic [5:0] HDR_LOAD  = 6'(MDIO_HDR_BITS - 1);
  localparam logic [5:0] TA_LOAD   = 6'd1;
  localparam logic [5:0] DATA_LOAD = 6'(MDIO_DATA_BITS - 1);

  mdio_state_t state, state_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [31:0] sr, sr_n;
  logic        wr, wr_n;
  logic        oe_n, o_n;
  logic [14:0] sin;
  logic        ta_err;
  logic        in_frame, last_bit, fall_stb, sample_stb;

  assign in_frame  = state inside {ST_PRE, ST_HDR, ST_TA, ST_DATA};
  assign last_bit  = (bit_cnt == 6'd0);
  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state == ST_DONE);

  eth_mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk        (clk),
    .rstn       (rstn),
    .en         (in_frame),
    .o_emdc     (o_emdc),
    .fall_stb   (fall_stb),
    .sample_stb (sample_stb)
  );

  // Next-state, bit counter and shift-out register; pad drive is derived from
  // the next state so mdio_o/mdio_oe are registered and change only at a fall.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    wr_n      = wr;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          wr_n = req_write;
          sr_n = mdio_frame(req_write, req_phy, req_reg, req_wdata);
          if (PREAMBLE_BITS == 0) begin
            state_n   = ST_HDR;
            bit_cnt_n = HDR_LOAD;
          end else begin
            state_n   = ST_PRE;
            bit_cnt_n = PRE_LOAD;
          end
        end
      end
      ST_PRE: begin
        if (fall_stb) begin
          if (last_bit) begin
            state_n   = ST_HDR;
            bit_cnt_n = HDR_LOAD;
          end else begin
            bit_cnt_n = bit_cnt - 6'd1;
          end
        end
      end
      ST_HDR: begin
        if (fall_stb) begin
          sr_n = {sr[30:0], 1'b0};
          if (last_bit) begin
            state_n   = ST_TA;
            bit_cnt_n = TA_LOAD;
          end else begin
            bit_cnt_n = bit_cnt - 6'd1;
          end
        end
      end
      ST_TA: begin
        if (fall_stb) begin
          sr_n = {sr[30:0], 1'b0};
          if (last_bit) begin
            state_n   = ST_DATA;
            bit_cnt_n = DATA_LOAD;
          end else begin
            bit_cnt_n = bit_cnt - 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (fall_stb) begin
          sr_n = {sr[30:0], 1'b0};
          if (last_bit) begin
            state_n   = ST_DONE;
            bit_cnt_n = 6'd0;
          end else begin
            bit_cnt_n = bit_cnt - 6'd1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Reads release the line from the first TA bit; preamble bits are all '1'.
    oe_n = (state_n == ST_PRE) || (state_n == ST_HDR) ||
           (wr_n && (state_n inside {ST_TA, ST_DATA}));
    o_n  = oe_n && ((state_n == ST_PRE) || sr_n[31]);
  end

  // FSM, counter, shift-out and registered pad drive.
  // NOTE: the shift registers are reset too, so nothing reaches the pad as X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      wr      <= 1'b0;
      mdio_o  <= 1'b0;
      mdio_oe <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      sr      <= sr_n;
      wr      <= wr_n;
      mdio_o  <= o_n;
      mdio_oe <= oe_n;
    end
  end

  // Read capture: TA bit 2 must be driven low by the PHY; data shifts in MSB
  // first and is published to the response registers with the final bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ta_err    <= 1'b0;
      sin       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (sample_stb) begin
      if (state == ST_TA && last_bit) begin
        ta_err <= mdio_i;
      end
      if (state == ST_DATA) begin
        sin <= {sin[13:0], mdio_i};
        if (last_bit) begin
          rsp_rdata <= wr ? 16'h0000 : {sin, mdio_i};
          rsp_err   <= ~wr & ta_err;
        end
      end
    end
  end

endmodule
